// File: rtl/lidar_packet_tx.sv
// Serializes a lidar scan packet (AA 55 CT LSN FSA LSA CS samples) onto a byte UART.
// First tx_start 1+LSN cycles after an accepted start; then one byte per tx_done handshake.
module lidar_packet_tx #(
    parameter int MAX_SAMPLES = 16
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           pkt_start_in,
    input  logic [7:0]                     ct_in,
    input  logic [7:0]                     lsn_in,
    input  logic [14:0]                    fsa_in,
    input  logic [14:0]                    lsa_in,
    input  logic                           sample_we_in,
    input  logic [$clog2(MAX_SAMPLES)-1:0] sample_addr_in,
    input  logic [15:0]                    sample_data_in,
    input  logic                           tx_done,
    output logic [7:0]                     tx_data,
    output logic                           tx_start,
    output logic                           busy_out,
    output logic                           pkt_done_out,
    output logic                           error_out
);
    localparam int AW = $clog2(MAX_SAMPLES);
    localparam int CW = $clog2(2 * MAX_SAMPLES + 11);

    typedef enum logic [2:0] {IDLE, CALC, SEND, WAIT, DONE} state_t;

    state_t        state;
    logic [15:0]   mem [MAX_SAMPLES];
    logic [7:0]    ct_q;
    logic [7:0]    lsn_q;
    logic [15:0]   fsa_w;
    logic [15:0]   lsa_w;
    logic [15:0]   cs;
    logic [7:0]    calc_idx;
    logic [CW-1:0] byte_idx;
    logic [CW-1:0] sel_idx;
    logic [CW-1:0] last_idx;
    logic [AW-1:0] word_idx;
    logic [15:0]   samp;
    logic [7:0]    nxt_byte;

    // Buffer is deliberately not reset so samples survive across packets and resets.
    always_ff @(posedge clk_in) begin
        if (sample_we_in && !busy_out) begin
            mem[sample_addr_in] <= sample_data_in;
        end
    end

    assign last_idx = CW'(16'd9 + {7'd0, lsn_q, 1'b0});

    // Byte to load on the next SEND: index 0 when leaving CALC, else the one after the current.
    always_comb begin
        sel_idx  = (state == CALC) ? '0 : byte_idx + CW'(1);
        word_idx = AW'((sel_idx - CW'(10)) >> 1);
        samp     = mem[word_idx];
        case (sel_idx)
            CW'(0):  nxt_byte = 8'hAA;
            CW'(1):  nxt_byte = 8'h55;
            CW'(2):  nxt_byte = ct_q;
            CW'(3):  nxt_byte = lsn_q;
            CW'(4):  nxt_byte = fsa_w[7:0];
            CW'(5):  nxt_byte = fsa_w[15:8];
            CW'(6):  nxt_byte = lsa_w[7:0];
            CW'(7):  nxt_byte = lsa_w[15:8];
            CW'(8):  nxt_byte = cs[7:0];
            CW'(9):  nxt_byte = cs[15:8];
            default: nxt_byte = sel_idx[0] ? samp[15:8] : samp[7:0];
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            tx_data      <= 8'd0;
            tx_start     <= 1'b0;
            busy_out     <= 1'b0;
            pkt_done_out <= 1'b0;
            error_out    <= 1'b0;
            ct_q         <= 8'd0;
            lsn_q        <= 8'd0;
            fsa_w        <= 16'd0;
            lsa_w        <= 16'd0;
            cs           <= 16'd0;
            calc_idx     <= 8'd0;
            byte_idx     <= '0;
        end else begin
            tx_start     <= 1'b0;
            pkt_done_out <= 1'b0;
            error_out    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pkt_start_in) begin
                        if (lsn_in == 8'd0 || 32'(lsn_in) > MAX_SAMPLES) begin
                            error_out <= 1'b1;
                        end else begin
                            ct_q     <= ct_in;
                            lsn_q    <= lsn_in;
                            fsa_w    <= {fsa_in, 1'b1};
                            lsa_w    <= {lsa_in, 1'b1};
                            cs       <= 16'h55AA ^ {fsa_in, 1'b1} ^ {lsn_in, ct_in} ^ {lsa_in, 1'b1};
                            calc_idx <= 8'd0;
                            busy_out <= 1'b1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    cs       <= cs ^ mem[calc_idx[AW-1:0]];
                    calc_idx <= calc_idx + 8'd1;
                    if (calc_idx == lsn_q - 8'd1) begin
                        tx_start <= 1'b1;
                        tx_data  <= nxt_byte;
                        byte_idx <= '0;
                        state    <= SEND;
                    end
                end
                SEND: state <= WAIT;
                WAIT: begin
                    if (tx_done) begin
                        if (byte_idx == last_idx) begin
                            pkt_done_out <= 1'b1;
                            busy_out     <= 1'b0;
                            state        <= DONE;
                        end else begin
                            tx_start <= 1'b1;
                            tx_data  <= nxt_byte;
                            byte_idx <= sel_idx;
                            state    <= SEND;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lidar_packet_tx.md
LIDAR_PACKET_TX -- requirements
Module: lidar_packet_tx

Interface
REQ-001 SHALL have parameter MAX_SAMPLES, default 16, giving the sample buffer depth and the maximum LSN accepted.
REQ-002 SHALL have port clk_in, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_in, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port pkt_start_in, input, 1, a one-cycle request to transmit one packet.
REQ-005 SHALL have port ct_in, input, 8, the CT byte (bit0=1 marks ring start).
REQ-006 SHALL have port lsn_in, input, 8, the sample count LSN.
REQ-007 SHALL have port fsa_in, input, 15, the raw first-sample angle.
REQ-008 SHALL have port lsa_in, input, 15, the raw last-sample angle.
REQ-009 SHALL have port sample_we_in, input, 1, the sample buffer write strobe.
REQ-010 SHALL have port sample_addr_in, input, $clog2(MAX_SAMPLES), the sample buffer write index.
REQ-011 SHALL have port sample_data_in, input, 16, the distance word.
REQ-012 SHALL have port tx_done, input, 1, a one-cycle pulse from the UART transmitter when the current byte is finished.
REQ-013 SHALL have port tx_data, output, 8, the byte to send.
REQ-014 SHALL have port tx_start, output, 1, a one-cycle pulse launching tx_data.
REQ-015 SHALL have port busy_out, output, 1, high from an accepted start until pkt_done_out.
REQ-016 SHALL have port pkt_done_out, output, 1, a one-cycle pulse after the last byte's tx_done.
REQ-017 SHALL have port error_out, output, 1, a one-cycle pulse when a start is rejected.

Function
REQ-018 SHALL emit, LSB first, the byte sequence: AA, 55, CT, LSN, FSA word, LSA word, CS word, then LSN sample words (packet length 10+2*LSN bytes).
REQ-019 SHALL encode the FSA word as {fsa_in,1'b1} and the LSA word as {lsa_in,1'b1}.
REQ-020 SHALL compute CS as the 16-bit XOR of 0x55AA, the FSA word, {LSN,CT}, the LSA word and every sample word 0..LSN-1.
REQ-021 SHALL latch ct_in, lsn_in, fsa_in and lsa_in on an accepted start; input changes during busy SHALL have no effect.
REQ-022 SHALL use the state machine IDLE -> CALC (one buffer word XORed per cycle, LSN cycles) -> SEND (tx_start=1 for one cycle) -> WAIT (hold until tx_done) -> SEND for the next byte, or DONE after the last byte -> IDLE.
REQ-023 SHALL assert tx_start in the cycle after the start is accepted plus the LSN CALC cycles (first tx_start at cycle 1+LSN after pkt_start_in).
REQ-024 SHALL hold tx_data stable from tx_start until tx_done, and SHALL issue the next tx_start on the cycle after tx_done.
REQ-025 SHALL ignore tx_done outside WAIT.
REQ-026 SHALL ignore pkt_start_in while busy_out=1 (no error pulse).
REQ-027 SHALL, for pkt_start_in in IDLE with lsn_in==0 or lsn_in>MAX_SAMPLES, pulse error_out the next cycle and remain IDLE with busy_out=0.
REQ-028 SHALL write the sample buffer only while busy_out=0 and SHALL ignore writes while busy_out=1.
REQ-029 SHALL keep the sample buffer contents across packets (no clear on reset).
REQ-030 SHALL pulse pkt_done_out one cycle after the final tx_done and drop busy_out in that same cycle.

Reset
REQ-031 SHALL, while rst_in=1, drive tx_data=0, tx_start=0, busy_out=0, pkt_done_out=0 and error_out=0, and enter IDLE.
REQ-032 SHALL, on reset mid-packet, abort with no further tx_start; the next accepted start SHALL send a full packet from byte AA.

Verification
REQ-033 SHALL pass this case: buffer[0]=0x0000, CT=0x00, LSN=1, FSA=0, LSA=0, tx_done returned 5 cycles after each tx_start -> bytes AA 55 00 01 01 00 01 00 AA 54 00 00, with pkt_done_out pulsed once.
REQ-034 SHALL pass this case: buffer={0x1234,0x5678}, CT=0x01, LSN=2, FSA=0x1000, LSA=0x1100 -> bytes AA 55 01 02 01 20 01 22 E7 11 34 12 78 56.
REQ-035 SHALL pass this case: LSN=0, then LSN=17 with MAX_SAMPLES=16 -> error_out pulses each time, no tx_start, busy_out stays 0.
REQ-036 SHALL pass this case: during a busy packet, a second pkt_start_in, a buffer write and a changed lsn_in -> the packet is unchanged and the buffer is unchanged afterwards.
REQ-037 SHALL pass this case: tx_done delayed 0 to 20 cycles randomly, plus a spurious tx_done in IDLE -> byte stream identical and tx_data stable during each WAIT.
REQ-038 SHALL pass this case: rst_in asserted after the 4th byte -> outputs take reset values next cycle, no further tx_start, and a following start sends a complete packet.
